// File: rtl/gpa_fhdo_dac_responder.sv
// gpa_fhdo_dac_responder: DAC80504-style SPI responder.
// It oversamples the SPI lines and keeps the SYNC, input and active DAC registers, with readback on SDO.
module gpa_fhdo_dac_responder #(
    parameter logic [15:0] DEVICE_ID  = 16'h0214,
    parameter logic [15:0] DAC_RESET  = 16'h8000,
    parameter logic [15:0] SYNC_RESET = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fhd_clk_i,
    input  logic        fhd_sdi_i,
    input  logic        fhd_csn_i,
    output logic        fhd_sdo_o,
    output logic [63:0] dac_o,
    output logic [3:0]  dac_update_o,
    output logic [15:0] sync_reg_o,
    output logic        frame_err_o
);
    logic [2:0]       sclk_q, sclk_d, csn_q, csn_d;
    logic [1:0]       sdi_q, sdi_d;
    logic             armed_q, armed_d, in_frame_q, in_frame_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [23:0]      shift_q, shift_d, tx_q, tx_d, tx_load;
    logic [20:0]      frame_q, frame_d;
    logic             cmt_q, cmt_d, bad_q, bad_d, sdo_q, sdo_d;
    logic             rd_vld_q, rd_vld_d;
    logic [3:0]       rd_addr_q, rd_addr_d, upd_q, upd_d, in_wr, act_wr, ld;
    logic [15:0]      sync_q, sync_d, rd_val, data;
    logic [3:0][15:0] in_q, in_d, act_q, act_d;
    logic             sclk_fall, csn_fall, csn_rise, wr, soft_rst, ldac;
    logic [3:0]       addr;

    always_comb begin
        sclk_d     = {sclk_q[1:0], fhd_clk_i};
        csn_d      = {csn_q[1:0], fhd_csn_i};
        sdi_d      = {sdi_q[0], fhd_sdi_i};
        sclk_fall  = sclk_q[2] & ~sclk_q[1];
        csn_fall   = csn_q[2] & ~csn_q[1];
        csn_rise   = ~csn_q[2] & csn_q[1];
        armed_d    = armed_q | csn_q[1];
        in_frame_d = in_frame_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        sdo_d      = sdo_q;
        rd_vld_d   = rd_vld_q;
        rd_addr_d  = rd_addr_q;
        rd_val     = rd_addr_q == 4'h1 ? DEVICE_ID :
                     rd_addr_q == 4'h2 ? sync_q :
                     rd_addr_q[3:2] == 2'b10 ? in_q[rd_addr_q[1:0]] : 16'h0000;
        tx_load    = rd_vld_q ? {4'b0000, rd_addr_q, rd_val} : 24'd0;
        // A pending readback is consumed by the very next frame, wanted or not
        if (csn_fall && armed_q) begin
            in_frame_d = 1'b1;
            bit_cnt_d  = 5'd0;
            sdo_d      = tx_load[23];
            tx_d       = {tx_load[22:0], 1'b0};
            rd_vld_d   = 1'b0;
        end else if (csn_q[1]) begin
            in_frame_d = 1'b0;
            sdo_d      = 1'b0;
            tx_d       = 24'd0;
        end else if (sclk_fall && in_frame_q) begin
            shift_d   = {shift_q[22:0], sdi_q[1]};
            bit_cnt_d = bit_cnt_q == 5'd31 ? bit_cnt_q : bit_cnt_q + 5'd1;
            sdo_d     = tx_q[23];
            tx_d      = {tx_q[22:0], 1'b0};
        end
        cmt_d    = csn_rise & in_frame_q & (bit_cnt_q == 5'd24);
        bad_d    = csn_rise & in_frame_q & (bit_cnt_q != 5'd24);
        frame_d  = csn_rise ? {shift_q[23], shift_q[19:0]} : frame_q;
        wr       = cmt_q & ~frame_q[20];
        addr     = frame_q[19:16];
        data     = frame_q[15:0];
        soft_rst = wr && addr == 4'h5 && data[3:0] == 4'b1010;
        ldac     = wr && addr == 4'h5 && data[4];
        if (cmt_q && frame_q[20]) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = addr;
        end
        sync_d = (wr && addr == 4'h2) ? data : sync_q;
        for (int k = 0; k < 4; k++) begin
            in_wr[k]  = wr && (addr == 4'(8 + k) || (addr == 4'h6 && sync_q[8 + k]));
            act_wr[k] = in_wr[k] & ~sync_q[k];
            ld[k]     = ldac & sync_q[k];
            in_d[k]   = in_wr[k] ? data : in_q[k];
            act_d[k]  = act_wr[k] ? data : ld[k] ? in_q[k] : act_q[k];
        end
        upd_d = act_wr | ld;
        if (soft_rst) begin
            sync_d    = SYNC_RESET;
            in_d      = {4{DAC_RESET}};
            act_d     = {4{DAC_RESET}};
            upd_d     = 4'd0;
            rd_vld_d  = 1'b0;
            rd_addr_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q     <= '0;
            csn_q      <= '0;
            sdi_q      <= '0;
            armed_q    <= 1'b0;
            in_frame_q <= 1'b0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= '0;
            frame_q    <= '0;
            cmt_q      <= 1'b0;
            bad_q      <= 1'b0;
            sdo_q      <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            upd_q      <= '0;
            sync_q     <= SYNC_RESET;
            in_q       <= {4{DAC_RESET}};
            act_q      <= {4{DAC_RESET}};
        end else begin
            sclk_q     <= sclk_d;
            csn_q      <= csn_d;
            sdi_q      <= sdi_d;
            armed_q    <= armed_d;
            in_frame_q <= in_frame_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            frame_q    <= frame_d;
            cmt_q      <= cmt_d;
            bad_q      <= bad_d;
            sdo_q      <= sdo_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            upd_q      <= upd_d;
            sync_q     <= sync_d;
            in_q       <= in_d;
            act_q      <= act_d;
        end
    end

    assign fhd_sdo_o    = sdo_q;
    assign dac_o        = act_q;
    assign dac_update_o = upd_q;
    assign sync_reg_o   = sync_q;
    assign frame_err_o  = bad_q;
endmodule

// File: tb/tb_gpa_fhdo_dac_responder.sv
// tb_gpa_fhdo_dac_responder: directed SPI frames against hand-computed register and readback values.
module tb_gpa_fhdo_dac_responder;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, sdi = 1'b0, csn = 1'b1;
    logic        sdo, err;
    logic [63:0] dac;
    logic [3:0]  upd, upd_seen;
    logic [15:0] sync;
    logic [23:0] rx;
    int          checks = 0, errors = 0, err_cnt;

    always #5 clk = ~clk;

    gpa_fhdo_dac_responder dut (
        .clk(clk), .rst(rst), .fhd_clk_i(sclk), .fhd_sdi_i(sdi), .fhd_csn_i(csn),
        .fhd_sdo_o(sdo), .dac_o(dac), .dac_update_o(upd), .sync_reg_o(sync), .frame_err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master samples SDO just before each rising edge, then drives SDI on that edge
    task automatic shift_bits(input logic [23:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            rx[23 - i] = sdo;
            sclk = 1'b1;
            sdi  = f[23 - i];
            tick(5);
            sclk = 1'b0;
            tick(5);
        end
    endtask

    task automatic watch();
        upd_seen = 4'd0;
        err_cnt  = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            upd_seen |= upd;
            err_cnt += err ? 1 : 0;
        end
        tick(4);
    endtask

    task automatic frame(input logic [23:0] f, input int n);
        rx  = 24'd0;
        csn = 1'b0;
        tick(5);
        shift_bits(f, 0, n);
        tick(3);
        csn = 1'b1;
        watch();
    endtask

    initial begin
        tick(3);
        check("rst_dac", dac, {4{16'h8000}});
        check("rst_sync", sync, 16'hFF00);
        check("rst_upd", upd, 4'd0);
        check("rst_err", err, 1'b0);
        check("rst_sdo", sdo, 1'b0);
        rst = 1'b0;
        tick(6);

        frame(24'h020000, 24);
        check("sync0", sync, 16'h0000);
        csn = 1'b0;
        tick(5);
        shift_bits(24'h08ABCD, 0, 24);
        tick(3);
        csn = 1'b1;
        tick(3);
        check("lat_early", upd, 4'd0);
        tick(1);
        check("lat_pulse", upd, 4'b0001);
        check("dac0", dac, {16'h8000, 16'h8000, 16'h8000, 16'hABCD});
        tick(1);
        check("lat_end", upd, 4'd0);
        tick(8);

        frame(24'h02000F, 24);
        frame(24'h091234, 24);
        check("gated_dac", dac, {16'h8000, 16'h8000, 16'h8000, 16'hABCD});
        check("gated_upd", upd_seen, 4'd0);
        frame(24'h050010, 24);
        check("ldac_dac", dac, {16'h8000, 16'h8000, 16'h1234, 16'hABCD});
        check("ldac_upd", upd_seen, 4'b1111);

        frame(24'h05000A, 24);
        check("soft_dac", dac, {4{16'h8000}});
        check("soft_sync", sync, 16'hFF00);

        frame(24'h020500, 24);
        frame(24'h06BEEF, 24);
        check("bcast_dac", dac, {16'h8000, 16'hBEEF, 16'h8000, 16'hBEEF});
        check("bcast_upd", upd_seen, 4'b0101);

        frame(24'h810000, 24);
        frame(24'h000000, 24);
        check("rd_id", rx, 24'h010214);
        check("sdo_idle", sdo, 1'b0);
        frame(24'h020123, 24);
        frame(24'h820000, 24);
        frame(24'h000000, 24);
        check("rd_sync", rx, 24'h020123);
        frame(24'h000000, 24);
        check("rd_none", rx, 24'h000000);

        frame(24'h0B1111, 23);
        check("trunc_err", err_cnt, 1);
        check("trunc_dac", dac, {16'h8000, 16'hBEEF, 16'h8000, 16'hBEEF});
        frame(24'h0B1111, 24);
        check("full_err", err_cnt, 0);
        check("full_dac", dac, {16'h1111, 16'hBEEF, 16'h8000, 16'hBEEF});
        check("full_upd", upd_seen, 4'b1000);

        csn = 1'b0;
        tick(5);
        shift_bits(24'h0A2222, 0, 10);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
        shift_bits(24'h0A2222, 10, 24);
        tick(3);
        csn = 1'b1;
        watch();
        check("midrst_err", err_cnt, 0);
        check("midrst_upd", upd_seen, 4'd0);
        check("midrst_dac", dac, {4{16'h8000}});
        frame(24'h0A2222, 24);
        check("after_dac", dac, {16'h8000, 16'h2222, 16'h8000, 16'h8000});
        check("after_upd", upd_seen, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
